// File: rtl/tmr_reg6_scrub_pkg.sv
// Shared constants for the triplicated PLL setting register and its voter.
package tmr_reg6_scrub_pkg;

  localparam int unsigned TMR_W = 6;

  localparam logic [1:0] COPY_A    = 2'd0;
  localparam logic [1:0] COPY_B    = 2'd1;
  localparam logic [1:0] COPY_C    = 2'd2;
  localparam logic [1:0] COPY_NONE = 2'd3;

  localparam int unsigned DEFAULT_SCRUB_PERIOD = 16;

endpackage

// File: rtl/tmr_reg6_scrub_if.sv
// Write, injection and status bundle between the config path and the TMR register.
interface tmr_reg6_scrub_if
  import tmr_reg6_scrub_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);

  logic             wr_en;
  logic [TMR_W-1:0] wr_data;
  logic             inj_en;
  logic [1:0]       inj_sel;
  logic [TMR_W-1:0] inj_mask;
  logic             err_clr;
  logic [TMR_W-1:0] q_a;
  logic [TMR_W-1:0] q_b;
  logic [TMR_W-1:0] q_c;
  logic [TMR_W-1:0] q_voted;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic             scrub_pulse;

  modport master (
    output wr_en, wr_data, inj_en, inj_sel, inj_mask, err_clr,
    input  q_a, q_b, q_c, q_voted, mismatch, err_cnt, scrub_pulse
  );

  modport slave (
    input  wr_en, wr_data, inj_en, inj_sel, inj_mask, err_clr,
    output q_a, q_b, q_c, q_voted, mismatch, err_cnt, scrub_pulse
  );

endinterface

// File: rtl/voter6bit.sv
// Bitwise 2-of-3 majority voter, same function as the downstream PLL voter.
module voter6bit
  import tmr_reg6_scrub_pkg::*;
(
  input  logic [TMR_W-1:0] a,
  input  logic [TMR_W-1:0] b,
  input  logic [TMR_W-1:0] c,
  output logic [TMR_W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_reg6_scrub.sv
// Triplicated 6-bit setting register with periodic majority scrub, upset counter
// and a test-only single-copy upset injector.
module tmr_reg6_scrub
  import tmr_reg6_scrub_pkg::*;
#(
  parameter logic [TMR_W-1:0] RESET_VAL    = '0,
  parameter int unsigned      SCRUB_PERIOD = DEFAULT_SCRUB_PERIOD,
  // Must match the CNT_W of the connected interface.
  parameter int unsigned      CNT_W        = 8
) (
  input logic             clk,
  input logic             rst,
  tmr_reg6_scrub_if.slave bus
);

  localparam int unsigned      SCNT_W    = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCRUB_PERIOD - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX   = '1;

  logic [SCNT_W-1:0] scnt_q;
  logic [TMR_W-1:0]  a_q, b_q, c_q;
  logic [TMR_W-1:0]  voted;
  logic [CNT_W-1:0]  err_q;
  logic              pulse_q;
  logic              tick;
  logic              mismatch;

  voter6bit u_voter (
    .a (a_q),
    .b (b_q),
    .c (c_q),
    .y (voted)
  );

  assign tick     = (scnt_q == SCNT_LAST);
  assign mismatch = (a_q != voted) | (b_q != voted) | (c_q != voted);

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q  <= '0;
      a_q     <= RESET_VAL;
      b_q     <= RESET_VAL;
      c_q     <= RESET_VAL;
      err_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      scnt_q  <= tick ? '0 : scnt_q + 1'b1;
      pulse_q <= 1'b0;
      if (bus.wr_en) begin
        a_q <= bus.wr_data;
        b_q <= bus.wr_data;
        c_q <= bus.wr_data;
      end else if (bus.inj_en && (bus.inj_sel != COPY_NONE)) begin
        // Injection pre-empts the scrub so an upset survives a coincident tick.
        case (bus.inj_sel)
          COPY_A:  a_q <= a_q ^ bus.inj_mask;
          COPY_B:  b_q <= b_q ^ bus.inj_mask;
          COPY_C:  c_q <= c_q ^ bus.inj_mask;
          default: ;
        endcase
      end else if (tick) begin
        a_q     <= voted;
        b_q     <= voted;
        c_q     <= voted;
        pulse_q <= 1'b1;
        if (mismatch && (err_q != ERR_MAX)) begin
          err_q <= err_q + 1'b1;
        end
      end
      if (bus.err_clr) begin
        err_q <= '0;
      end
    end
  end

  assign bus.q_a         = a_q;
  assign bus.q_b         = b_q;
  assign bus.q_c         = c_q;
  assign bus.q_voted     = voted;
  assign bus.mismatch    = mismatch;
  assign bus.err_cnt     = err_q;
  assign bus.scrub_pulse = pulse_q;

endmodule

// File: tb/tb_tmr_reg6_scrub.sv
// Scenario bench for tmr_reg6_scrub: expected snapshots are queued with each stimulus
// and popped for comparison after the clock edge that should produce them.
module tb_tmr_reg6_scrub;

  localparam logic [5:0]  RV  = 6'h2A;
  localparam int unsigned PER = 16;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] c;
    logic [5:0] v;
    logic       mm;
    logic [7:0] err;
    logic       pulse;
  } snap_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   phase;
  int   err_m;
  snap_t sb[$];
  snap_t e;
  snap_t o;

  tmr_reg6_scrub_if #(.CNT_W(8)) bus ();

  tmr_reg6_scrub #(
    .RESET_VAL    (RV),
    .SCRUB_PERIOD (PER),
    .CNT_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic snap_t mk(logic [5:0] a, logic [5:0] b, logic [5:0] c, logic [5:0] v,
                               logic mm, logic [7:0] err, logic pulse);
    snap_t s;
    s.a = a; s.b = b; s.c = c; s.v = v; s.mm = mm; s.err = err; s.pulse = pulse;
    return s;
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.a = bus.q_a; s.b = bus.q_b; s.c = bus.q_c; s.v = bus.q_voted;
    s.mm = bus.mismatch; s.err = bus.err_cnt; s.pulse = bus.scrub_pulse;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("a=%h b=%h c=%h v=%h mm=%b err=%0d pulse=%b",
                     s.a, s.b, s.c, s.v, s.mm, s.err, s.pulse);
  endfunction

  // Tracks the DUT scrub counter value after each edge.
  task automatic step();
    @(posedge clk);
    if (rst) phase = 0;
    else phase = (phase == PER - 1) ? 0 : phase + 1;
    #1;
  endtask

  task automatic to_phase(input int p);
    for (int i = 0; i < PER && phase != p; i++) step();
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.inj_en = 1'b0;
    bus.inj_sel = 2'd3; bus.inj_mask = '0; bus.err_clr = 1'b0;
  endtask

  task automatic inject(input logic [1:0] sel, input logic [5:0] mask);
    bus.inj_en = 1'b1; bus.inj_sel = sel; bus.inj_mask = mask;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 6'h3F; inject(2'd0, 6'h3F); bus.err_clr = 1'b0;
    step();
    sb.push_back(mk(RV, RV, RV, RV, 1'b0, 8'd0, 1'b0));
    step();
    rst = 1'b0; idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL reset: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_write_inject();
    bus.wr_en = 1'b1; bus.wr_data = 6'h15;
    sb.push_back(mk(6'h15, 6'h15, 6'h15, 6'h15, 1'b0, 8'd0, 1'b0));
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL write: got %s want %s", fmt(o), fmt(e)); end
    inject(2'd1, 6'h01);
    sb.push_back(mk(6'h15, 6'h14, 6'h15, 6'h15, 1'b1, 8'd0, 1'b0));
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL inject_b: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_scrub();
    for (int i = 0; i < PER && phase != PER - 1; i++) begin
      sb.push_back(mk(6'h15, 6'h14, 6'h15, 6'h15, 1'b1, 8'd0, 1'b0));
      step();
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL scrub_hold: got %s want %s", fmt(o), fmt(e)); end
    end
    err_m = 1;
    sb.push_back(mk(6'h15, 6'h15, 6'h15, 6'h15, 1'b0, 8'd1, 1'b1));
    step();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL scrub_tick: got %s want %s", fmt(o), fmt(e)); end
    sb.push_back(mk(6'h15, 6'h15, 6'h15, 6'h15, 1'b0, 8'd1, 1'b0));
    step();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL scrub_pulse_end: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_write_on_tick();
    inject(2'd1, 6'h01);
    sb.push_back(mk(6'h15, 6'h14, 6'h15, 6'h15, 1'b1, 8'd1, 1'b0));
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL reinject_b: got %s want %s", fmt(o), fmt(e)); end
    to_phase(PER - 1);
    bus.wr_en = 1'b1; bus.wr_data = 6'h3F;
    sb.push_back(mk(6'h3F, 6'h3F, 6'h3F, 6'h3F, 1'b0, 8'd1, 1'b0));
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL write_on_tick: got %s want %s", fmt(o), fmt(e)); end
    sb.push_back(mk(6'h3F, 6'h3F, 6'h3F, 6'h3F, 1'b0, 8'd1, 1'b0));
    step();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL after_write_tick: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_double_upset();
    bus.wr_en = 1'b1; bus.wr_data = 6'h00;
    sb.push_back(mk(6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 8'd1, 1'b0));
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL write_zero: got %s want %s", fmt(o), fmt(e)); end
    inject(2'd0, 6'h04);
    sb.push_back(mk(6'h04, 6'h00, 6'h00, 6'h00, 1'b1, 8'd1, 1'b0));
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL inject_a: got %s want %s", fmt(o), fmt(e)); end
    inject(2'd2, 6'h04);
    sb.push_back(mk(6'h04, 6'h00, 6'h04, 6'h04, 1'b1, 8'd1, 1'b0));
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL inject_c: got %s want %s", fmt(o), fmt(e)); end
    inject(2'd3, 6'h3F);
    sb.push_back(mk(6'h04, 6'h00, 6'h04, 6'h04, 1'b1, 8'd1, 1'b0));
    if (phase == PER - 1) sb[0].pulse = 1'b1;
    if (phase == PER - 1) sb[0] = mk(6'h04, 6'h04, 6'h04, 6'h04, 1'b0, 8'd2, 1'b1);
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL inject_none: got %s want %s", fmt(o), fmt(e)); end
    if (!e.pulse) begin
      to_phase(PER - 1);
      sb.push_back(mk(6'h04, 6'h04, 6'h04, 6'h04, 1'b0, 8'd2, 1'b1));
      step();
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL uncorrectable: got %s want %s", fmt(o), fmt(e)); end
    end
    err_m = 2;
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 260; k++) begin
      to_phase(PER - 2);
      inject(2'(k % 3), 6'(1 << (k % 6)));
      step(); idle();
      err_m = (err_m < 255) ? err_m + 1 : 255;
      sb.push_back(mk(6'h04, 6'h04, 6'h04, 6'h04, 1'b0, 8'(err_m), 1'b1));
      step();
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL sat_tick%0d: got %s want %s", k, fmt(o), fmt(e)); end
    end
    to_phase(PER - 2);
    inject(2'd1, 6'h10);
    step(); idle();
    bus.err_clr = 1'b1;
    sb.push_back(mk(6'h04, 6'h04, 6'h04, 6'h04, 1'b0, 8'd0, 1'b1));
    step(); idle();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL clr_on_tick: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_reset_mid();
    int n;
    to_phase(6);
    inject(2'd0, 6'h01);
    step(); idle();
    rst = 1'b1;
    sb.push_back(mk(RV, RV, RV, RV, 1'b0, 8'd0, 1'b0));
    step();
    rst = 1'b0;
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_mid: got %s want %s", fmt(o), fmt(e)); end
    n = 0;
    for (int i = 1; i <= 3 * PER && n == 0; i++) begin
      step();
      if (bus.scrub_pulse === 1'b1) n = i;
    end
    total++;
    if (n != PER) begin
      bad++;
      $display("FAIL reset_restart: first pulse after %0d edges, want %0d", n, PER);
    end
  endtask

  initial begin
    total = 0; bad = 0; phase = 0; err_m = 0;
    rst = 1'b1; idle();
    test_reset();
    test_write_inject();
    test_scrub();
    test_write_on_tick();
    test_double_upset();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmr_reg6_scrub.md
Name: tmr_reg6_scrub

Overview:
- Triplicated 6-bit storage register that directly feeds the 6-bit majority voter stage in the PLL control path.
- Holds three copies (A/B/C) of a 6-bit setting and exposes them to the voter.
- Periodically scrubs all copies back to the majority value, counts corrected upsets, and provides a test-only upset-injection port.
- Sits between the configuration write path and the voter; the voted value drives PLL settings.

Parameters:
- RESET_VAL, 6'h00, value loaded into all three copies on reset.
- SCRUB_PERIOD, 16, clock cycles between scrub ticks (legal range 1..1024; 1 means scrub every cycle).
- CNT_W, 8, width of the saturating corrected-error counter.

Ports:
- clk  input  1  block clock
- rst  input  1  synchronous active-high reset
- wr_en  input  1  write strobe; loads wr_data into all copies
- wr_data  input  6  value to write
- inj_en  input  1  test-only upset injection strobe
- inj_sel  input  2  target copy: 0=A, 1=B, 2=C, 3=none
- inj_mask  input  6  bits XORed into the target copy
- err_clr  input  1  clears err_cnt
- q_a, q_b, q_c  output  6 each  register copies, to voter inputs A/B/C
- q_voted  output  6  bitwise majority of the copies (combinational from the registers)
- mismatch  output  1  high when any copy differs from q_voted (combinational)
- err_cnt  output  CNT_W  saturating count of scrub corrections
- scrub_pulse  output  1  one-cycle pulse in the cycle after a scrub is applied

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - q_a = q_b = q_c = RESET_VAL; err_cnt = 0; scrub_pulse = 0; scrub counter = 0.
  - Reset overrides every other input in that cycle.
  - Reset asserted mid-scrub-interval restarts the interval from 0.
- Scrub counter:
  - Counts 0..SCRUB_PERIOD-1 and wraps to 0.
  - tick = (count == SCRUB_PERIOD-1). For SCRUB_PERIOD=1, tick is high every cycle.
  - Free-running; it is not affected by writes or injection.
- Per-cycle update priority (highest first):
  1. wr_en=1: all copies <= wr_data. Injection and scrub are ignored that cycle; scrub_pulse next cycle = 0.
  2. inj_en=1 and inj_sel!=3: selected copy <= copy XOR inj_mask; other copies hold. Scrub is skipped even on a tick. inj_sel=3 makes injection a no-op, and the cycle falls through to rule 3.
  3. tick=1: all copies <= q_voted; scrub_pulse=1 in the next cycle.
     - If mismatch=1 in the tick cycle, err_cnt increments, saturating at 2^CNT_W-1.
     - A tick with mismatch=0 still pulses scrub_pulse but leaves err_cnt unchanged.
  4. Otherwise all copies hold.
- Voting: q_voted[i] = (a&b)|(a&c)|(b&c), bitwise, identical to the downstream voter. A write is visible on q_voted one cycle after the wr_en edge.
- Counter clear: err_clr=1 sets err_cnt = 0. If err_clr and a counting scrub coincide, the result is err_cnt = 0 (clear wins).
- Multi-copy upsets: two copies upset on the same bit cannot be corrected. The scrub propagates the wrong majority to all three copies, counts one correction, and this is accepted behaviour.
- Outputs q_a/q_b/q_c and err_cnt come directly from flops; no combinational path from inputs to outputs except through q_voted/mismatch of the registered copies.

Decomposition:
- Shared package holds:
  - constant TMR_W = 6
  - copy-select encodings COPY_A=2'd0, COPY_B=2'd1, COPY_C=2'd2, COPY_NONE=2'd3
  - default scrub period constant
- Sub-module: instantiate the existing voter6bit for q_voted rather than duplicating the majority logic.
- Scrub counter stays inline.

Test Plan:
- Reset with RESET_VAL=6'h2A -> q_a=q_b=q_c=q_voted=6'h2A, mismatch=0, err_cnt=0, scrub_pulse=0.
- Write 6'h15 -> next cycle all copies and q_voted = 6'h15. Then inject inj_sel=1, inj_mask=6'h01 -> q_b=6'h14, q_voted=6'h15, mismatch=1.
- Continuing from the injection, with SCRUB_PERIOD=16 -> at the next tick q_b returns to 6'h15, mismatch=0, err_cnt=1, scrub_pulse high for exactly one cycle.
- wr_en=1 with wr_data=6'h3F in the same cycle as a tick while q_b is corrupted -> all copies = 6'h3F, err_cnt unchanged, scrub_pulse=0.
- Inject the same bit into A and then C (mask 6'h04) on a stored value of 6'h00, then tick -> all copies = 6'h04, err_cnt+1 (uncorrectable case propagates).
- Force 260 corrections with CNT_W=8 -> err_cnt saturates at 255. Assert err_clr on a correcting tick -> err_cnt=0. Assert rst mid-interval -> first tick occurs SCRUB_PERIOD cycles after rst deasserts.
